// File: rtl/pc_redirect_unit_pkg.sv
// Shared front-end definitions: fetch FSM state encoding and sequential PC step.
package pc_redirect_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_redirect_unit_mux.sv
// Parametric N:1 mux, purely combinational (zero latency); carries no flow control.
module pc_redirect_unit_mux #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] din,
  input  logic [SEL_W-1:0]            sel,
  output logic [WIDTH-1:0]            dout
);

  assign dout = din[sel];

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator with EX-stage redirects; PC/misalign registered (1 cycle), flushes combinational.
// Backpressure: imem_ready low holds the PC; a redirect that misses the accept parks in PEND.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mpc,
  input  logic        jalr,
  input  logic [31:0] branch_target,
  input  logic [31:0] jalr_target,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        misalign
);

  import pc_redirect_unit_pkg::*;

  pc_state_e         state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pend_target_q, pend_target_d;
  logic              misalign_q, misalign_d;
  logic              imem_req_q, imem_req_d;
  logic [31:0]       tgt;
  logic [1:0][31:0]  tgt_opts;
  logic              accept;

  // JALR targets drop bit 0; bit 1 is left alone so misalignment stays visible.
  assign tgt_opts = {{jalr_target[31:1], 1'b0}, branch_target};

  pc_redirect_unit_mux #(
    .WIDTH (32),
    .DEPTH (2)
  ) u_tgt_mux (
    .din  (tgt_opts),
    .sel  (jalr),
    .dout (tgt)
  );

  assign accept = imem_req_q & imem_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    imem_req_d    = 1'b1;
    misalign_d    = mpc & tgt[1];
    flush_ifid    = 1'b0;
    flush_idex    = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end

      RUN: begin
        if (mpc) begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          if (accept) begin
            pc_d = tgt;
          end else begin
            pend_target_d = tgt;
            state_d       = PEND;
          end
        end else if (!stall && accept) begin
          pc_d = pc_q + PC_STEP;
        end
      end

      PEND: begin
        if (mpc) begin
          flush_ifid    = 1'b1;
          flush_idex    = 1'b1;
          pend_target_d = tgt;
        end
        // The fetch accepted here is still on the wrong path, so IF/ID is squashed.
        if (accept) begin
          flush_ifid = 1'b1;
          pc_d       = mpc ? tgt : pend_target_q;
          state_d    = RUN;
        end
      end

      default: begin
        state_d    = BOOT;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'd0;
      misalign_q    <= 1'b0;
      imem_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      misalign_q    <= misalign_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign imem_req = imem_req_q;
  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + PC_STEP;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboarded bench for pc_redirect_unit: per-cycle predictions queued at drive time, compared at negedge.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mpc, jalr, stall, imem_ready;
  logic [31:0] branch_target, jalr_target;
  logic        imem_req, flush_ifid, flush_idex, misalign;
  logic [31:0] pc_out, pc_plus4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic        req;
    logic        fi;
    logic        fx;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: 0 = boot, 1 = run, 2 = pending redirect
  int          m_st;
  logic [31:0] m_pc, m_ptgt;
  logic        m_mis;

  pc_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mpc           (mpc),
    .jalr          (jalr),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .stall         (stall),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .flush_ifid    (flush_ifid),
    .flush_idex    (flush_idex),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st   = 0;
    m_pc   = 32'h0;
    m_ptgt = 32'h0;
    m_mis  = 1'b0;
  endtask

  // Called at posedge+1: drive, predict, compare at negedge, then advance to the next posedge+1.
  task automatic step(input logic m, input logic j, input logic st, input logic rdy,
                      input logic [31:0] bt, input logic [31:0] jt);
    exp_t        e;
    exp_t        got;
    logic [31:0] t;
    logic        acc;
    int          n_st;
    logic [31:0] n_pc, n_ptgt;
    mpc = m; jalr = j; stall = st; imem_ready = rdy;
    branch_target = bt; jalr_target = jt;

    t     = j ? (jt & 32'hFFFF_FFFE) : bt;
    e.pc  = m_pc;
    e.p4  = m_pc + 32'd4;
    e.req = (m_st != 0);
    e.mis = m_mis;
    e.fx  = (m_st != 0) && m;
    e.fi  = (m_st != 0) && (m || (m_st == 2 && rdy));
    sb_q.push_back(e);

    acc = e.req && rdy;
    n_st = m_st; n_pc = m_pc; n_ptgt = m_ptgt;
    if (m_st == 0) begin
      n_st = 1;
    end else if (m_st == 1) begin
      if (m) begin
        if (acc) n_pc = t;
        else begin n_ptgt = t; n_st = 2; end
      end else if (!st && acc) begin
        n_pc = m_pc + 32'd4;
      end
    end else begin
      if (m) n_ptgt = t;
      if (acc) begin n_pc = m ? t : m_ptgt; n_st = 1; end
    end

    @(negedge clk);
    got = sb_q.pop_front();
    check_val("pc_out",     pc_out,     got.pc);
    check_val("pc_plus4",   pc_plus4,   got.p4);
    check_val("imem_req",   {31'b0, imem_req},   {31'b0, got.req});
    check_val("flush_ifid", {31'b0, flush_ifid}, {31'b0, got.fi});
    check_val("flush_idex", {31'b0, flush_idex}, {31'b0, got.fx});
    check_val("misalign",   {31'b0, misalign},   {31'b0, got.mis});

    @(posedge clk);
    #1;
    m_st = n_st; m_pc = n_pc; m_ptgt = n_ptgt; m_mis = m && t[1];
  endtask

  initial begin
    rst_n = 1'b0;
    mpc = 1'b1; jalr = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    branch_target = 32'h44; jalr_target = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pc",       pc_out,                32'h0);
    check_val("rst_req",      {31'b0, imem_req},     32'h0);
    check_val("rst_flush_if", {31'b0, flush_ifid},   32'h0);
    check_val("rst_flush_ex", {31'b0, flush_idex},   32'h0);
    check_val("rst_misalign", {31'b0, misalign},     32'h0);
    rst_n = 1'b1;

    // Boot sequence: 0, 0, 4, 8 then 12
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    check_val("boot_pc12", pc_out, 32'hC);
    check_val("boot_req",  {31'b0, imem_req}, 32'h1);

    // Branch redirect with accept
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0);
    check_val("br_pc100", pc_out, 32'h100);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
    check_val("br_pc40", pc_out, 32'h40);

    // JALR with bit 0 cleared and bit 1 misaligned
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h203);
    check_val("jalr_pc", pc_out, 32'h202);
    check_val("jalr_mis", {31'b0, misalign}, 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    check_val("mis_pulse_end", {31'b0, misalign}, 32'h0);
    check_val("stall_hold", pc_out, 32'h202);

    // Redirect waiting on imem_ready; stall ignored on the accept cycle
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    check_val("pend_hold", pc_out, 32'h80);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    check_val("pend_pc300", pc_out, 32'h300);

    // Newest pending redirect wins
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    check_val("pend_pc500", pc_out, 32'h500);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h600, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h700, 32'h0);
    check_val("pend_same_cyc", pc_out, 32'h700);

    // Wrap at the top of the address space; stall vs redirect priority
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    check_val("wrap_stall_hold", pc_out, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    check_val("wrap_zero", pc_out, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0);
    check_val("stall_redirect", pc_out, 32'h10);

    // Reset while a redirect is pending drops it
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h900, 32'h0);
    rst_n = 1'b0;
    #1;
    check_val("pend_rst_pc",  pc_out, 32'h0);
    check_val("pend_rst_req", {31'b0, imem_req}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    check_val("post_rst_pc", pc_out, 32'h8);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
           $urandom, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 mpc  input  1  SHALL be the EX-stage branch-controller "take redirect" flag.
REQ-005 jalr  input  1  SHALL select jalr_target when set, branch_target when clear; it is only meaningful with mpc=1.
REQ-006 branch_target  input  32  SHALL be the EX-stage PC+imm target.
REQ-007 jalr_target  input  32  SHALL be the EX-stage rs1+imm target.
REQ-008 stall  input  1  SHALL be the hazard-unit hold request for the front end.
REQ-009 imem_ready  input  1  SHALL mean the instruction memory accepts the current fetch this cycle.
REQ-010 imem_req  output  1  SHALL mean a fetch of pc_out is requested.
REQ-011 pc_out  output  32  SHALL be the registered fetch PC.
REQ-012 pc_plus4  output  32  SHALL be pc_out+4, combinational, modulo 2^32.
REQ-013 flush_ifid, flush_idex  output  1 each  SHALL be the squash controls for the IF/ID and ID/EX registers.
REQ-014 misalign  output  1  SHALL be a registered one-cycle pulse flagging a redirect target with bit 1 set.

Function
REQ-015 Target selection SHALL be: tgt = jalr ? {jalr_target[31:1],1'b0} : branch_target.
REQ-016 The FSM SHALL have exactly three states: BOOT, RUN and PEND.
REQ-017 In BOOT, imem_req SHALL be 0 and the next state SHALL be RUN unconditionally.
REQ-018 In RUN and PEND, imem_req SHALL be 1.
REQ-019 Accept SHALL be defined as imem_req & imem_ready.
REQ-020 Request stability: once imem_req=1, pc_out SHALL NOT change until an accept.
REQ-021 RUN, mpc=1, accept: pc_out SHALL load tgt and the state SHALL remain RUN.
REQ-022 RUN, mpc=1, no accept: pend_target SHALL load tgt, pc_out SHALL hold, and the state SHALL go to PEND.
REQ-023 In any RUN cycle with mpc=1, flush_ifid and flush_idex SHALL both be 1 combinationally, irrespective of stall and imem_ready.
REQ-024 RUN, mpc=0, stall=1: pc_out SHALL hold; stall SHALL override accept for PC advance.
REQ-025 RUN, mpc=0, stall=0, accept: pc_out SHALL load pc_out+4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-026 RUN, mpc=0, stall=0, no accept: pc_out SHALL hold.
REQ-027 PEND, no accept: pc_out SHALL hold.
REQ-028 PEND, mpc=1: pend_target SHALL be overwritten with the new tgt (newest wins), and flush_ifid and flush_idex SHALL be 1.
REQ-029 PEND, accept: pc_out SHALL load pend_target (or the tgt of a same-cycle mpc), flush_ifid SHALL be 1 to squash the wrong-path fetch, and the state SHALL go to RUN.
REQ-030 In PEND, stall SHALL be ignored.
REQ-031 Priority SHALL be: redirect, then stall, then sequential advance.
REQ-032 misalign SHALL be 1 in the cycle after any cycle where mpc=1 and tgt[1]=1.
REQ-033 A misaligned target SHALL still be loaded unmodified apart from the JALR bit-0 clear.
REQ-034 flush_ifid and flush_idex SHALL be 0 in every case not covered by REQ-023, REQ-028 and REQ-029.

Reset
REQ-035 While rst_n=0, asynchronously: pc_out=RESET_PC, pend_target=0, state=BOOT, misalign=0.
REQ-036 While rst_n=0: imem_req=0, flush_ifid=0, flush_idex=0.
REQ-037 Reset asserted in PEND SHALL discard the pending redirect.
REQ-038 The first fetch after reset release SHALL be RESET_PC, requested one cycle after release.

Structure
REQ-039 The state encoding (BOOT=2'd0, RUN=2'd1, PEND=2'd2) and the constant PC_STEP=32'd4 SHALL reside in the shared core package.
REQ-040 The only sub-module SHALL be a 2:1 target mux instantiated from the existing parametric mux with width 32 and depth 2.

Verification
REQ-041 Reset release with imem_ready=1, no stall: pc_out SHALL read 0, 0, 4, 8, 12 on consecutive cycles after release, and imem_req SHALL rise one cycle after release.
REQ-042 pc_out=0x100, mpc=1, jalr=0, branch_target=0x40, imem_ready=1: both flushes SHALL be 1 that cycle, then pc_out=0x40 and state RUN.
REQ-043 mpc=1, jalr=1, jalr_target=0x203: next pc_out SHALL be 0x202 and misalign SHALL pulse 1 for one cycle.
REQ-044 pc_out=0x80, mpc=1, tgt=0x300, imem_ready=0 for 3 cycles then 1: pc_out SHALL stay 0x80 through the wait; on the accept cycle flush_ifid=1; then pc_out=0x300.
REQ-045 In PEND with pend_target=0x300, a new mpc with tgt=0x500 before the accept: pc_out SHALL become 0x500 after the accept.
REQ-046 pc_out=0xFFFF_FFFC, accept, no stall: next pc_out SHALL be 0x0; with stall=1 and mpc=0, pc_out SHALL hold; with stall=1 and mpc=1, the redirect SHALL be taken.
